// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM encoding, LDI opcode and
// instruction field positions.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int INSTR_W = 8;

    localparam logic [2:0] OP_LDI = 3'b111;

    // instr = {op[2:0], rd[1:0], rs[1:0], use_imm}
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 1;
    localparam int IMM_BIT = 0;

    function automatic logic is_ldi(input logic [2:0] op);
        return op == OP_LDI;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4-entry register file: one synchronous write port and three asynchronous
// read ports (rd operand, rs operand, debug).
module alu_seq_regfile #(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] REG_RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        rd_addr,
    input  logic [1:0]        rs_addr,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= REG_RST_VAL;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rd_data  = regs[rd_addr];
    assign rs_data  = regs[rs_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Load/operate sequencer around a combinational 8-bit ALU: accept, execute,
// retire in three cycles. Optional retire counter under ALU_SEQ_RETIRE_CNT_EN.
//
// state | meaning
// IDLE  | ready for an instruction; operands launched on accept
// EXEC  | ALU settles; result (or immediate for LDI) written to R[rd]
// DONE  | one-cycle retire pulse, then back to IDLE
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] REG_RST_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [DATA_W-1:0]  imm_in,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [DATA_W-1:0]  alu_r,
    input  logic               alu_zero,
    input  logic [1:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
`ifdef ALU_SEQ_RETIRE_CNT_EN
    output logic [7:0]         retire_cnt,
`endif
    output logic               zero_flag,
    output logic               done
);

    state_t state_q, state_d;

    logic [2:0]        in_op;
    logic [1:0]        in_rd;
    logic [1:0]        in_rs;
    logic              in_use_imm;

    logic [2:0]        op_q;
    logic [1:0]        rd_q;
    logic [DATA_W-1:0] imm_q;

    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rs_data;

    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_zero;

    assign in_op      = instr_in[OP_MSB:OP_LSB];
    assign in_rd      = instr_in[RD_MSB:RD_LSB];
    assign in_rs      = instr_in[RS_MSB:RS_LSB];
    assign in_use_imm = instr_in[IMM_BIT];

    alu_seq_regfile #(
        .DATA_W      (DATA_W),
        .REG_RST_VAL (REG_RST_VAL)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (wr_en),
        .waddr    (rd_q),
        .wdata    (wr_data),
        .rd_addr  (in_rd),
        .rs_addr  (in_rs),
        .dbg_addr (dbg_sel),
        .rd_data  (rd_data),
        .rs_data  (rs_data),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        wr_en       = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                wr_en   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // LDI bypasses the ALU entirely; its zero status comes from the immediate.
    always_comb begin
        wr_data = alu_r;
        wr_zero = alu_zero;
        if (is_ldi(op_q)) begin
            wr_data = imm_q;
            wr_zero = (imm_q == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else if (accept) begin
            op_q       <= in_op;
            rd_q       <= in_rd;
            imm_q      <= imm_in;
            alu_a      <= rd_data;
            alu_b      <= in_use_imm ? imm_in : rs_data;
            alu_opcode <= is_ldi(in_op) ? 3'd0 : in_op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_flag <= 1'b0;
        end else if (wr_en) begin
            zero_flag <= wr_zero;
        end
    end

`ifdef ALU_SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= 8'd0;
        end else if (done) begin
            retire_cnt <= retire_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU stub; table-driven
// instruction vectors plus reset, backpressure and abort sequences.
module tb_alu_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_in;
    logic [7:0] imm_in;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_r;
    logic       alu_zero;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    logic       zero_flag;
    logic       done;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [7:0] retire_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alu_seq_ctrl #(.DATA_W(8), .REG_RST_VAL(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_in    (instr_in),
        .imm_in      (imm_in),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_r       (alu_r),
        .alu_zero    (alu_zero),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data),
`ifdef ALU_SEQ_RETIRE_CNT_EN
        .retire_cnt  (retire_cnt),
`endif
        .zero_flag   (zero_flag),
        .done        (done)
    );

    // ALU stub: 0 add, 1 sub, 2 and, 3 or, 4 xor, otherwise pass A
    always_comb begin
        case (alu_opcode)
            3'd0:    alu_r = alu_a + alu_b;
            3'd1:    alu_r = alu_a - alu_b;
            3'd2:    alu_r = alu_a & alu_b;
            3'd3:    alu_r = alu_a | alu_b;
            3'd4:    alu_r = alu_a ^ alu_b;
            default: alu_r = alu_a;
        endcase
        alu_zero = (alu_r == 8'h00);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] imm;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [2:0] exp_op;
        logic [7:0] exp_rd;
        logic       exp_z;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            ok = 1'b0;
            check("ready_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_in    = v.instr;
        imm_in      = v.imm;
        wait_ready(ok);
        if (!ok) begin
            instr_valid = 1'b0;
            return;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        check($sformatf("v%0d_exec_alu_a", idx), {24'd0, alu_a}, {24'd0, v.exp_a});
        check($sformatf("v%0d_exec_alu_b", idx), {24'd0, alu_b}, {24'd0, v.exp_b});
        check($sformatf("v%0d_exec_alu_op", idx), {29'd0, alu_opcode}, {29'd0, v.exp_op});
        check($sformatf("v%0d_exec_ready", idx), {31'd0, instr_ready}, 32'd0);
        check($sformatf("v%0d_exec_done", idx), {31'd0, done}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd1);
        check($sformatf("v%0d_done_ready", idx), {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_idle_done", idx), {31'd0, done}, 32'd0);
        check($sformatf("v%0d_idle_ready", idx), {31'd0, instr_ready}, 32'd1);
        check($sformatf("v%0d_hold_alu_a", idx), {24'd0, alu_a}, {24'd0, v.exp_a});
        dbg_sel = v.instr[4:3];
        #1;
        check($sformatf("v%0d_rd_value", idx), {24'd0, dbg_data}, {24'd0, v.exp_rd});
        check($sformatf("v%0d_zero_flag", idx), {31'd0, zero_flag}, {31'd0, v.exp_z});
    endtask

    task automatic issue_only(input logic [7:0] ins, input logic [7:0] imm);
        bit ok;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_in    = ins;
        imm_in      = imm;
        wait_ready(ok);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int  accepts;
        logic [7:0] last_imm;
        bit  saw_done;

        //            instr   imm    a      b      op    rd_val z
        vecs[0]  = '{8'hE8, 8'h05, 8'h00, 8'h00, 3'd0, 8'h05, 1'b0}; // LDI r1,05
        vecs[1]  = '{8'hF0, 8'h03, 8'h00, 8'h00, 3'd0, 8'h03, 1'b0}; // LDI r2,03
        vecs[2]  = '{8'h0C, 8'h00, 8'h05, 8'h03, 3'd0, 8'h08, 1'b0}; // ADD r1,r2
        vecs[3]  = '{8'hF8, 8'h0F, 8'h00, 8'h00, 3'd0, 8'h0F, 1'b0}; // LDI r3,0F
        vecs[4]  = '{8'h59, 8'hF0, 8'h0F, 8'hF0, 3'd2, 8'h00, 1'b1}; // AND r3,#F0
        vecs[5]  = '{8'hF0, 8'h00, 8'h03, 8'h00, 3'd0, 8'h00, 1'b1}; // LDI r2,00
        vecs[6]  = '{8'h2A, 8'h00, 8'h08, 8'h08, 3'd1, 8'h00, 1'b1}; // SUB r1,r1
        vecs[7]  = '{8'hE0, 8'h7F, 8'h00, 8'h00, 3'd0, 8'h7F, 1'b0}; // LDI r0,7F
        vecs[8]  = '{8'h88, 8'h00, 8'h00, 8'h7F, 3'd4, 8'h7F, 1'b0}; // XOR r1,r0
        vecs[9]  = '{8'h09, 8'h81, 8'h7F, 8'h81, 3'd0, 8'h00, 1'b1}; // ADD r1,#81 wraps
        vecs[10] = '{8'h70, 8'h00, 8'h00, 8'h7F, 3'd3, 8'h7F, 1'b0}; // OR r2,r0

        reset       = 1'b0;
        instr_valid = 1'b0;
        instr_in    = 8'h00;
        imm_in      = 8'h00;
        dbg_sel     = 2'd0;

        #13 reset = 1'b1;
        #10 reset = 1'b0;
        @(negedge clk);
        check("rst_zero_flag", {31'd0, zero_flag}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_alu_a", {24'd0, alu_a}, 32'd0);
        check("rst_alu_op", {29'd0, alu_opcode}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = i[1:0];
            #1;
            check($sformatf("rst_r%0d", i), {24'd0, dbg_data}, 32'd0);
        end
`ifdef ALU_SEQ_RETIRE_CNT_EN
        check("rst_retire_cnt", {24'd0, retire_cnt}, 32'd0);
`endif

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // Valid held for 10 cycles while the instruction changes every cycle.
        @(negedge clk);
        accepts  = 0;
        last_imm = 8'h00;
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            instr_in = 8'hE0;
            imm_in   = 8'h10 + 8'(i);
            if (instr_ready) begin
                accepts++;
                last_imm = imm_in;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_accepts", accepts, 32'd4);
        check("bp_last_imm", {24'd0, last_imm}, 32'h19);
        dbg_sel = 2'd0;
        #1;
        check("bp_r0_value", {24'd0, dbg_data}, 32'h19);

        // Reset during EXEC of LDI r0,AA must drop the instruction.
        @(negedge clk);
        instr_valid = 1'b1;
        instr_in    = 8'hE0;
        imm_in      = 8'hAA;
        @(posedge clk);
        #2;
        instr_valid = 1'b0;
        check("abort_in_exec", {31'd0, instr_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("abort_done_rst", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        check("abort_ready", {31'd0, instr_ready}, 32'd1);
        dbg_sel = 2'd0;
        #1;
        check("abort_r0", {24'd0, dbg_data}, 32'h00);
        check("abort_zero_flag", {31'd0, zero_flag}, 32'd0);

`ifdef ALU_SEQ_RETIRE_CNT_EN
        check("abort_retire_cnt", {24'd0, retire_cnt}, 32'd0);
        issue_only(8'hE8, 8'h01);
        check("retire_cnt_one", {24'd0, retire_cnt}, 32'd1);
        for (int i = 0; i < 254; i++) begin
            issue_only(8'hE8, 8'h01);
        end
        check("retire_cnt_255", {24'd0, retire_cnt}, 32'd255);
        issue_only(8'hE8, 8'h01);
        check("retire_cnt_wrap", {24'd0, retire_cnt}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
